// File: rtl/xbar_input_port.sv
// Crossbar ingress port: store-and-forward FIFO, arbiter request/grant
// handshake, and egress streaming of one packet per grant.
//
// Handshakes: a word moves on ingress when in_valid & in_ready are both high
// at a rising edge, and on egress when out_valid & out_ready are both high.
// A valid word is held stable until it moves. in_ready does not depend on
// in_valid, and out_valid does not depend on out_ready.
module xbar_input_port #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 8,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic          req,
  output logic [DW-1:0] addr,
  output logic [2:0]    state,
  input  logic [11:0]   answer,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          err_oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // The state codes are also the values driven on the arbiter's State bus.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_REQ  = 3'b001,
    ST_XFER = 3'b010,
    ST_REL  = 3'b100
  } state_t;

  state_t        st, st_nxt;
  logic [DW:0]   mem [DEPTH];   // {last, data}
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;         // words held
  logic [CW-1:0] pkt_cnt;       // complete packets held
  logic          drop;          // discarding the rest of an oversize packet
  logic          full, empty;
  logic [DW:0]   head;
  logic          in_xfer, push, pop;
  logic          head_last, push_last;
  logic          drop_pending;
  logic          grant;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_last = head[DW];

  // A full FIFO with no complete packet can never drain: it is flushed on the
  // next edge and the remainder of that packet is swallowed.
  assign drop_pending = full & (pkt_cnt == '0) & ~pop;

  // in_ready is forced low while reset is held.
  assign in_ready  = reset & (drop | (~full & ~drop_pending));
  assign in_xfer   = in_valid & in_ready;
  assign push      = in_xfer & ~drop;
  assign push_last = push & in_last;
  assign pop       = out_valid & out_ready;

  // Grant: any valid Answer slice naming this input as its source.
  always_comb begin
    grant = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (answer[3*j+2] && (answer[3*j +: 2] == 2'(PORT_ID))) grant = 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // Pointers, occupancy, packet count, and oversize drop/flush control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pkt_cnt      <= '0;
      drop         <= 1'b0;
      err_oversize <= 1'b0;
    end else if (drop_pending) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop         <= 1'b1;
      err_oversize <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({push_last, pop & head_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (drop && in_xfer && in_last) drop <= 1'b0;
    end
  end

  // Port state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  // Next state: a last-word push is looked at directly so that req rises in
  // the cycle right after the packet completes.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if ((pkt_cnt != '0) || push_last) st_nxt = ST_REQ;
      ST_REQ:  if (grant)                        st_nxt = ST_XFER;
      ST_XFER: if (pop && head_last)             st_nxt = ST_REL;
      ST_REL:                                    st_nxt = ST_IDLE;
      default:                                   st_nxt = ST_IDLE;
    endcase
  end

  // Arbiter-facing and egress outputs decoded from state and FIFO head.
  always_comb begin
    state     = st;
    req       = (st == ST_REQ);
    addr      = req ? head[DW-1:0] : '0;
    out_valid = (st == ST_XFER) & ~empty;
    out_data  = out_valid ? head[DW-1:0] : '0;
    out_last  = out_valid & head_last;
  end

endmodule
